// File: rtl/i2s_tdm_rx_if.sv
// Sample-side bus of the serial audio receiver: one-cycle strobes plus lock status.
// master = receiver driving samples, slave = DSP consumer.
interface i2s_tdm_rx_if #(
  parameter int SAMPLE_W = 24,
  parameter int CHAN_W   = 1
);
  logic [SAMPLE_W-1:0] sample_data;
  logic [CHAN_W-1:0]   sample_chan;
  logic                sample_valid;
  logic                frame_err;
  logic                locked;

  modport master (output sample_data, sample_chan, sample_valid, frame_err, locked);
  modport slave  (input  sample_data, sample_chan, sample_valid, frame_err, locked);
endinterface

// File: rtl/i2s_tdm_rx.sv
// I2S / left-justified / TDM receiver. bck, lrck and din are oversampled in the
// clk domain; every detected bck rise is one bit position inside a slot/frame.
module i2s_tdm_rx #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2,
  parameter int MODE_I2S = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bck_i,
  input  logic         lrck_i,
  input  logic         din_i,
  i2s_tdm_rx_if.master smp
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // One spare bit so the window test below can use wrap-around subtraction.
  localparam int CNT_W  = $clog2(SLOT_W) + 1;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0]  CAP_FIRST = CNT_W'(MODE_I2S);
  localparam logic [CNT_W-1:0]  CAP_LAST  = CNT_W'(MODE_I2S + SAMPLE_W - 1);
  localparam logic [CNT_W-1:0]  CAP_LEN   = CNT_W'(SAMPLE_W);
  localparam logic [CHAN_W-1:0] LAST_SLOT = CHAN_W'(CHANNELS - 1);

  typedef enum logic {WAIT_SYNC = 1'b0, RUN = 1'b1} state_t;
  state_t state_q, state_d;

  logic bck_s1_q, bck_s2_q, bck_s3_q;
  logic lrck_s1_q, lrck_s2_q, lrck_q, lrck_prev_q;
  logic din_s1_q, din_s2_q, din_q;
  logic rise_q;

  logic [CNT_W-1:0]    bit_q, bit_d, bit_inc;
  logic [CHAN_W-1:0]   slot_q, slot_d, slot_inc;
  logic [SAMPLE_W-2:0] sh_q;
  logic [SAMPLE_W-1:0] sh_d, data_q;
  logic [CHAN_W-1:0]   chan_q;
  logic                valid_q, valid_d, err_q, err_d;
  logic                fall, active, cap, last_bit, at_start;

  // Two-flop synchronisers plus one more stage; rise_q, lrck_q and din_q all
  // leave the same stage, so data and frame clock are read with the bck edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bck_s1_q  <= 1'b0; bck_s2_q  <= 1'b0; bck_s3_q <= 1'b0;
      lrck_s1_q <= 1'b0; lrck_s2_q <= 1'b0; lrck_q   <= 1'b0;
      din_s1_q  <= 1'b0; din_s2_q  <= 1'b0; din_q    <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      bck_s1_q  <= bck_i;    bck_s2_q  <= bck_s1_q;  bck_s3_q <= bck_s2_q;
      lrck_s1_q <= lrck_i;   lrck_s2_q <= lrck_s1_q; lrck_q   <= lrck_s2_q;
      din_s1_q  <= din_i;    din_s2_q  <= din_s1_q;  din_q    <= din_s2_q;
      rise_q    <= bck_s2_q & ~bck_s3_q;
    end
  end

  // Position of the current bck rise: natural increment, or frame start on an lrck fall.
  always_comb begin
    fall     = rise_q & lrck_prev_q & ~lrck_q;
    bit_inc  = (bit_q == LAST_BIT) ? '0 : bit_q + 1'b1;
    slot_inc = slot_q;
    if (bit_q == LAST_BIT) slot_inc = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
    at_start = (bit_inc == '0) && (slot_inc == '0);
    bit_d    = fall ? '0 : bit_inc;
    slot_d   = fall ? '0 : slot_inc;
    active   = rise_q & ((state_q == RUN) | fall);
    cap      = active & ((bit_d - CAP_FIRST) < CAP_LEN);
    last_bit = cap & (bit_d == CAP_LAST);
    sh_d     = {sh_q, din_q};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_SYNC;
    else     state_q <= state_d;
  end

  // FSM next state: the first lrck fall locks; only reset returns to WAIT_SYNC.
  always_comb begin
    state_d = state_q;
    if ((state_q == WAIT_SYNC) && fall) state_d = RUN;
  end

  // FSM outputs: a fall off the expected frame start is an error and kills any
  // sample completing on the same edge.
  always_comb begin
    err_d      = (state_q == RUN) & fall & ~at_start;
    valid_d    = last_bit & ~err_d;
    smp.locked = (state_q == RUN);
  end

  // Counters, shift register and output sample registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q       <= '0;
      slot_q      <= '0;
      lrck_prev_q <= 1'b0;
      sh_q        <= '0;
      data_q      <= '0;
      chan_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (active) begin
        bit_q  <= bit_d;
        slot_q <= slot_d;
      end
      if (rise_q)  lrck_prev_q <= lrck_q;
      if (cap)     sh_q        <= sh_d[SAMPLE_W-2:0];
      if (valid_d) begin
        data_q <= sh_d;
        chan_q <= slot_d;
      end
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign smp.sample_data  = data_q;
  assign smp.sample_chan  = chan_q;
  assign smp.sample_valid = valid_q;
  assign smp.frame_err    = err_q;
endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Bench for i2s_tdm_rx: three instances (stereo I2S, left-justified 16-bit,
// 8-slot TDM) fed one after another from bit streams built here. A frame-level
// model turns each stream into expected events, which are scheduled against
// the clk cycle of each bck pin rise and checked every cycle.
module tb_i2s_tdm_rx;
  localparam int KEYM = 1 << 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] bck_p = '0, lrck_p = '0, din_p = '0;

  always #5 clk = ~clk;

  i2s_tdm_rx_if #(.SAMPLE_W(24), .CHAN_W(1)) if0 ();
  i2s_tdm_rx_if #(.SAMPLE_W(16), .CHAN_W(1)) if1 ();
  i2s_tdm_rx_if #(.SAMPLE_W(24), .CHAN_W(3)) if2 ();

  i2s_tdm_rx #(.SAMPLE_W(24), .SLOT_W(32), .CHANNELS(2), .MODE_I2S(1)) u0 (
    .clk(clk), .rst(rst), .bck_i(bck_p[0]), .lrck_i(lrck_p[0]), .din_i(din_p[0]), .smp(if0));
  i2s_tdm_rx #(.SAMPLE_W(16), .SLOT_W(16), .CHANNELS(2), .MODE_I2S(0)) u1 (
    .clk(clk), .rst(rst), .bck_i(bck_p[1]), .lrck_i(lrck_p[1]), .din_i(din_p[1]), .smp(if1));
  i2s_tdm_rx #(.SAMPLE_W(24), .SLOT_W(32), .CHANNELS(8), .MODE_I2S(1)) u2 (
    .clk(clk), .rst(rst), .bck_i(bck_p[2]), .lrck_i(lrck_p[2]), .din_i(din_p[2]), .smp(if2));

  logic [31:0] o_data [3];
  logic [31:0] o_chan [3];
  logic        o_v [3], o_e [3], o_l [3];
  assign o_data[0] = {8'd0, if0.sample_data};
  assign o_data[1] = {16'd0, if1.sample_data};
  assign o_data[2] = {8'd0, if2.sample_data};
  assign o_chan[0] = {31'd0, if0.sample_chan};
  assign o_chan[1] = {31'd0, if1.sample_chan};
  assign o_chan[2] = {29'd0, if2.sample_chan};
  assign o_v[0] = if0.sample_valid; assign o_v[1] = if1.sample_valid; assign o_v[2] = if2.sample_valid;
  assign o_e[0] = if0.frame_err;    assign o_e[1] = if1.frame_err;    assign o_e[2] = if2.frame_err;
  assign o_l[0] = if0.locked;       assign o_l[1] = if1.locked;       assign o_l[2] = if2.locked;

  function automatic int c_sw(int k);  return (k == 1) ? 16 : 32; endfunction
  function automatic int c_saw(int k); return (k == 1) ? 16 : 24; endfunction
  function automatic int c_ch(int k);  return (k == 2) ? 8 : 2;   endfunction
  function automatic int c_md(int k);  return (k == 1) ? 0 : 1;   endfunction

  int npass = 0, nchk = 0, cyc = 0;
  int err_cnt [3] = '{0, 0, 0};
  bit rs;
  int key_c, kind_c;

  // Stream under construction: lrck/din per bck period, reset before the period's rise.
  bit s_lr[$], s_dn[$], s_rb[$];
  // Model output per bck rise: bit0 sample, bit1 frame error, bit2 lock.
  int          m_kind[$];
  logic [31:0] m_data[$], m_chan[$];
  // Expected events keyed by DUT*KEYM + cycle.
  int          ev_kind [int];
  logic [31:0] ev_data [int], ev_chan [int];
  logic [31:0] e_data [3], e_chan [3];
  bit          e_lock [3];
  // Strobes seen from the DUTs.
  int          log_k[$];
  logic [31:0] log_d[$], log_c[$];
  logic [31:0] fw [16];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, k, cyc, act, exp);
  endtask

  // Per-cycle compare of every output of every instance.
  initial begin
    for (int k = 0; k < 3; k++) begin e_data[k] = 0; e_chan[k] = 0; e_lock[k] = 0; end
  end
  always begin
    @(posedge clk);
    cyc++;
    rs = rst;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      key_c  = k * KEYM + cyc;
      kind_c = ev_kind.exists(key_c) ? ev_kind[key_c] : 0;
      if (rs) begin kind_c = 0; e_data[k] = 0; e_chan[k] = 0; e_lock[k] = 0; end
      if ((kind_c & 1) != 0) begin e_data[k] = ev_data[key_c]; e_chan[k] = ev_chan[key_c]; end
      if ((kind_c & 4) != 0) e_lock[k] = 1'b1;
      chk("sample_valid", k, 32'(o_v[k]), 32'((kind_c & 1) != 0));
      chk("frame_err",    k, 32'(o_e[k]), 32'((kind_c & 2) != 0));
      chk("locked",       k, 32'(o_l[k]), 32'(e_lock[k]));
      chk("sample_data",  k, o_data[k], e_data[k]);
      chk("sample_chan",  k, o_chan[k], e_chan[k]);
      if (o_v[k]) begin log_k.push_back(k); log_d.push_back(o_data[k]); log_c.push_back(o_chan[k]); end
      if (o_e[k]) err_cnt[k]++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic clear_stream();
    s_lr.delete(); s_dn.delete(); s_rb.delete();
  endtask

  // n idle periods with lrck high so the next frame start is a real fall.
  task automatic add_pre(input int n);
    for (int i = 0; i < n; i++) begin
      s_lr.push_back(1'b1); s_dn.push_back(1'($urandom_range(0, 1))); s_rb.push_back(1'b0);
    end
  endtask

  // First len periods of a frame carrying fw[slot]; lrck low for the first half.
  task automatic add_frame(input int k, input int len);
    int sw, L, p, s, md, saw;
    logic b;
    sw = c_sw(k); L = c_ch(k) * sw; md = c_md(k); saw = c_saw(k);
    for (int j = 0; j < len; j++) begin
      p = j % sw; s = j / sw;
      if (p >= md && p < md + saw) b = fw[s][saw - 1 - (p - md)];
      else b = 1'($urandom_range(0, 1));
      s_lr.push_back(j >= L / 2); s_dn.push_back(b); s_rb.push_back(1'b0);
    end
  endtask

  // Frame-level reference: between lrck falls at f and f2, rise i sits at
  // offset i-f; samples end at offset MODE+SAMPLE_W-1 of each slot, and a fall
  // not a whole number of frames after f is an error.
  task automatic run_model(input int k);
    int f, L, sw, saw, md, ch, kind, j;
    bit prev;
    logic [31:0] w, cn;
    f = -1; prev = 1'b0;
    sw = c_sw(k); saw = c_saw(k); md = c_md(k); ch = c_ch(k); L = ch * sw;
    m_kind.delete(); m_data.delete(); m_chan.delete();
    for (int i = 0; i < s_lr.size(); i++) begin
      kind = 0; w = 0; cn = 0;
      if (s_rb[i]) begin f = -1; prev = 1'b0; end
      if (prev && !s_lr[i]) begin
        if (f < 0) kind |= 4;
        else if (((i - f) % L) != 0) kind |= 2;
        f = i;
      end
      prev = s_lr[i];
      if (f >= 0) begin
        j = i - f;
        if ((j % sw) == md + saw - 1) begin
          kind |= 1;
          cn = 32'((j / sw) % ch);
          for (int b = 0; b < saw; b++) w = {w[30:0], 1'(s_dn[i - saw + 1 + b])};
        end
      end
      m_kind.push_back(kind); m_data.push_back(w); m_chan.push_back(cn);
    end
  endtask

  // Plays the stream, h clk per half bck period; events land 4 clk after each pin rise.
  task automatic drive_stream(input int k, input int h);
    int key;
    for (int i = 0; i < s_lr.size(); i++) begin
      bck_p[k] = 1'b0; lrck_p[k] = s_lr[i]; din_p[k] = s_dn[i];
      if (s_rb[i]) begin
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
      end
      repeat (h) @(posedge clk);
      #1 bck_p[k] = 1'b1;
      if (m_kind[i] != 0) begin
        key = k * KEYM + cyc + 4;
        ev_kind[key] = m_kind[i]; ev_data[key] = m_data[i]; ev_chan[key] = m_chan[i];
      end
      repeat (h) @(posedge clk);
      #1;
    end
    bck_p[k] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  function automatic int model_samples();
    int n = 0;
    foreach (m_kind[i]) if ((m_kind[i] & 1) != 0) n++;
    return n;
  endfunction

  function automatic int log_count(input int k);
    int n = 0;
    foreach (log_k[i]) if (log_k[i] == k) n++;
    return n;
  endfunction

  task automatic chk_log(input int k, input int n, input logic [31:0] d, input logic [31:0] c);
    int cnt;
    logic [31:0] ad, ac;
    cnt = 0; ad = 32'hDEAD_BEEF; ac = 32'hFFFF_FFFF;
    foreach (log_k[i]) if (log_k[i] == k) begin
      if (cnt == n) begin ad = log_d[i]; ac = log_c[i]; end
      cnt++;
    end
    chk($sformatf("strobe%0d data", n), k, ad, d);
    chk($sformatf("strobe%0d chan", n), k, ac, c);
  endtask

  initial begin
    int base, first;
    real ph, dph;
    int v;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // ---- stereo I2S: basic, short frame, reset mid-slot, sine sweep
    clear_stream();
    add_pre(5);
    fw[0] = 32'h123456; fw[1] = 32'hABCDEF; add_frame(0, 64); add_frame(0, 64);
    fw[0] = 32'h111111; fw[1] = 32'h999999; add_frame(0, 54);     // lrck falls 10 bck early in slot 1
    fw[0] = 32'h222222; fw[1] = 32'h333333; add_frame(0, 64);
    fw[0] = 32'h666666; fw[1] = 32'h777777; base = s_lr.size(); add_frame(0, 64);
    s_rb[base + 12] = 1'b1;                                          // reset before bit 12 of slot 0
    fw[0] = 32'h444444; fw[1] = 32'h555555; add_frame(0, 64);
    ph = 0.0; dph = 0.01;
    for (int fr = 0; fr < 150; fr++) begin
      v = $rtoi(8000000.0 * $sin(ph));
      fw[0] = 32'(v); fw[1] = 32'(-v);
      ph = ph + dph; dph = dph + 0.002;
      add_frame(0, 64);
    end
    run_model(0);
    first = -1;
    foreach (m_kind[i]) if (first < 0 && (m_kind[i] & 1) != 0) first = i;
    chk("model first sample", 0, (first >= 0) ? m_data[first] : 32'hFFFF_FFFF, 32'h123456);
    chk("model first index", 0, 32'(first), 32'(5 + 24));
    chk("model sample count", 0, 32'(model_samples()), 32'd309);
    drive_stream(0, 2);
    chk_log(0, 0, 32'h123456, 0); chk_log(0, 1, 32'hABCDEF, 1);
    chk_log(0, 2, 32'h123456, 0); chk_log(0, 3, 32'hABCDEF, 1);
    chk_log(0, 4, 32'h111111, 0); chk_log(0, 5, 32'h222222, 0);
    chk_log(0, 6, 32'h333333, 1); chk_log(0, 7, 32'h444444, 0);
    chk_log(0, 8, 32'h555555, 1);
    chk("strobe count", 0, 32'(log_count(0)), 32'd309);
    chk("frame_err count", 0, 32'(err_cnt[0]), 32'd1);
    chk("locked at end", 0, 32'(o_l[0]), 32'd1);

    // ---- left-justified 16-bit stereo
    clear_stream();
    add_pre(5);
    fw[0] = 32'h8000; fw[1] = 32'h7FFF; add_frame(1, 32); add_frame(1, 32);
    for (int fr = 0; fr < 4; fr++) begin
      fw[0] = $urandom_range(0, 32'hFFFF); fw[1] = $urandom_range(0, 32'hFFFF); add_frame(1, 32);
    end
    run_model(1);
    drive_stream(1, 2);
    chk_log(1, 0, 32'h8000, 0); chk_log(1, 1, 32'h7FFF, 1);
    chk_log(1, 2, 32'h8000, 0); chk_log(1, 3, 32'h7FFF, 1);
    chk("strobe count", 1, 32'(log_count(1)), 32'd12);
    chk("frame_err count", 1, 32'(err_cnt[1]), 32'd0);

    // ---- 8-slot TDM, slot n carries 0x0000n1
    clear_stream();
    add_pre(5);
    for (int s = 0; s < 8; s++) fw[s] = 32'((s << 4) | 1);
    for (int fr = 0; fr < 3; fr++) add_frame(2, 256);
    for (int s = 0; s < 8; s++) fw[s] = $urandom_range(0, 32'hFFFFFF);
    add_frame(2, 256);
    run_model(2);
    drive_stream(2, 3);
    for (int n = 0; n < 24; n++) chk_log(2, n, 32'(((n % 8) << 4) | 1), 32'(n % 8));
    chk("strobe count", 2, 32'(log_count(2)), 32'd32);
    chk("frame_err count", 2, 32'(err_cnt[2]), 32'd0);
    chk("locked at end", 2, 32'(o_l[2]), 32'd1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
